// File: rtl/msdf_pkg.sv
// msdf_pkg: shared definitions for the MSDF online multiplier and its
// on-the-fly converter. Holds the borrow-save digit encoding {p,n}
// (value = p - n), the converter FSM state type and a digit decoder.
package msdf_pkg;

   localparam logic [1:0] SD_POS  = 2'b10;   // +1
   localparam logic [1:0] SD_NEG  = 2'b01;   // -1
   localparam logic [1:0] SD_ZERO = 2'b00;   //  0 (2'b11 is also zero)

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } conv_state_t;

   // Decode a borrow-save digit to +1 / 0 / -1. Both {0,0} and {1,1}
   // cancel to zero, so only the two asymmetric codes carry a value.
   function automatic logic signed [1:0] sd_value(input logic [1:0] d);
      logic signed [1:0] v;
      v = 2'sd0;
      if (d == SD_POS)
         v = 2'sd1;
      else if (d == SD_NEG)
         v = -2'sd1;
      return v;
   endfunction

endpackage

// File: rtl/msdf_otf_converter.sv
// msdf_otf_converter: on-the-fly conversion of an MSD-first signed-digit
// product stream (N+1 radix-2 digits) into an (N+2)-bit two's-complement word.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   start             - pulse: clear converter and begin a new product
//   digit_in          - borrow-save digit {p,n}, qualified by digit_valid
//   busy              - high while digits are being accepted (CONV)
//   result            - converted value (driven from Q in every state)
//   result_valid      - high while in DONE; result is stable
module msdf_otf_converter
   import msdf_pkg::*;
#(
   parameter int N = 9
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [1:0]     digit_in,
   input  logic           digit_valid,
   output logic           busy,
   output logic [N+1:0]   result,
   output logic           result_valid
);

   localparam int CNT_W = $clog2(N + 2);

   conv_state_t       state;
   logic [N+1:0]      q;
   logic [N+1:0]      qm;      // always q - 1
   logic [N+1:0]      q_nxt;
   logic [N+1:0]      qm_nxt;
   logic [CNT_W-1:0]  cnt;
   logic signed [1:0] z;

   // Append the new digit to both candidates. A -1 digit would require a
   // borrow out of Q; taking QM (= Q-1) instead absorbs it, and a +1 digit
   // makes Q*2 the new "minus one" form. No carry chain is ever needed.
   always_comb begin
      z      = sd_value(digit_in);
      q_nxt  = {q[N:0], 1'b0};
      qm_nxt = {qm[N:0], 1'b1};
      if (z == 2'sd1) begin
         q_nxt  = {q[N:0], 1'b1};
         qm_nxt = {q[N:0], 1'b0};
      end else if (z == -2'sd1) begin
         q_nxt  = {qm[N:0], 1'b1};
         qm_nxt = {qm[N:0], 1'b0};
      end
   end

   // start overrides everything but rst in every state, and any digit
   // presented with it is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         q     <= '0;
         qm    <= '1;
         cnt   <= '0;
      end else if (start) begin
         state <= CONV;
         q     <= '0;
         qm    <= '1;
         cnt   <= '0;
      end else if (state == CONV && digit_valid) begin
         q   <= q_nxt;
         qm  <= qm_nxt;
         cnt <= cnt + 1'b1;
         if (cnt == CNT_W'(N))
            state <= DONE;
      end
   end

   assign busy         = (state == CONV);
   assign result_valid = (state == DONE);
   assign result       = q;

endmodule

// File: tb/tb_msdf_otf_converter.sv
module tb_msdf_otf_converter;
   import msdf_pkg::*;

   localparam int N = 9;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [1:0]    digit_in;
   logic          digit_valid;
   logic          busy;
   logic [N+1:0]  result;
   logic          result_valid;

   int checks = 0;
   int errors = 0;

   msdf_otf_converter #(.N(N)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .digit_in     (digit_in),
      .digit_valid  (digit_valid),
      .busy         (busy),
      .result       (result),
      .result_valid (result_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      string        name;
      logic [19:0]  digits;   // first (MSD) digit in [19:18]
      int           gap;      // idle cycles between digits
      logic [10:0]  exp;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Inputs change 1ns after the rising edge; outputs are read there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send(input logic [1:0] d);
      digit_valid = 1'b1;
      digit_in    = d;
      tick();
      digit_valid = 1'b0;
      digit_in    = SD_ZERO;
   endtask

   vec_t vecs[4];
   logic [10:0] held;

   initial begin
      vecs[0] = '{"all_pos",  20'hAAAAA, 0, 11'h3FF};
      vecs[1] = '{"all_neg",  20'h55555, 0, 11'h401};
      vecs[2] = '{"pos_neg",  20'h93333, 0, 11'h100};
      vecs[3] = '{"gapped",   20'h80001, 3, 11'h1FF};

      rst = 1'b1; start = 1'b0; digit_in = SD_ZERO; digit_valid = 1'b0;
      tick(); tick();
      chk("reset_busy",  32'(busy), 0);
      chk("reset_valid", 32'(result_valid), 0);
      chk("reset_result", 32'(result), 0);
      rst = 1'b0;
      tick();

      foreach (vecs[v]) begin
         do_start();
         chk({vecs[v].name, "_busy_start"}, 32'(busy), 1);
         chk({vecs[v].name, "_clear"}, 32'(result), 0);
         for (int i = 0; i < 10; i++) begin
            logic [19:0] tmp;
            tmp = vecs[v].digits;
            if (i == 9) begin
               chk({vecs[v].name, "_no_early_valid"}, 32'(result_valid), 0);
               chk({vecs[v].name, "_busy_before_last"}, 32'(busy), 1);
            end
            send(tmp[19-2*i -: 2]);
            if (i < 9 && vecs[v].gap > 0) begin
               held = result;
               for (int g = 0; g < vecs[v].gap; g++) tick();
               chk({vecs[v].name, "_gap_hold"}, 32'(result), 32'(held));
               chk({vecs[v].name, "_gap_busy"}, 32'(busy), 1);
            end
         end
         chk({vecs[v].name, "_valid"}, 32'(result_valid), 1);
         chk({vecs[v].name, "_busy_done"}, 32'(busy), 0);
         chk({vecs[v].name, "_result"}, 32'(result), 32'(vecs[v].exp));
         if (v == 2) chk("pos_neg_qm", 32'(dut.qm), 32'h0FF);
         tick();
         chk({vecs[v].name, "_result_held"}, 32'(result), 32'(vecs[v].exp));
      end

      // Abort: start arriving with a digit restarts and drops that digit.
      do_start();
      for (int i = 0; i < 4; i++) send(SD_POS);
      start = 1'b1; digit_valid = 1'b1; digit_in = SD_POS;
      tick();
      start = 1'b0; digit_valid = 1'b0;
      chk("abort_cleared", 32'(result), 0);
      for (int i = 0; i < 9; i++) send(i[0] ? 2'b11 : SD_ZERO);
      chk("abort_not_done_9", 32'(result_valid), 0);
      chk("abort_busy_9", 32'(busy), 1);
      send(SD_ZERO);
      chk("abort_valid_10", 32'(result_valid), 1);
      chk("abort_result", 32'(result), 0);

      // Mid-conversion reset.
      do_start();
      for (int i = 0; i < 3; i++) send(SD_POS);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_valid", 32'(result_valid), 0);
      chk("midrst_result", 32'(result), 0);

      // Digits in IDLE are ignored.
      send(SD_POS); send(SD_NEG);
      chk("idle_digit_result", 32'(result), 0);
      chk("idle_digit_busy", 32'(busy), 0);

      // Digits in DONE are ignored; start from DONE clears.
      do_start();
      for (int i = 0; i < 10; i++) send(SD_NEG);
      send(SD_POS); send(SD_POS);
      chk("done_digit_result", 32'(result), 32'h401);
      chk("done_digit_valid", 32'(result_valid), 1);
      do_start();
      chk("done_restart_busy", 32'(busy), 1);
      chk("done_restart_valid", 32'(result_valid), 0);
      chk("done_restart_result", 32'(result), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
